// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access sequencer.
// Build option: MEM_TIMEOUT_EN enables the REQ timeout (see mem_access_ctrl.sv).
package mem_access_ctrl_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

    // Encodings kept fixed so waveforms match the documented state values.
    typedef enum logic [1:0] {
        MacIdle = 2'd0,
        MacReq  = 2'd1,
        MacDone = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// REQ-phase wait counter with synchronous clear, enable and terminal-count flag.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_cnt #(
    parameter int unsigned MaxCount = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CntW = (MaxCount > 1) ? $clog2(MaxCount) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last allowed REQ cycle.
    assign tc_o = (cnt_q == CntW'(MaxCount - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: req/ack handshake with a
// variable-latency memory, pipeline freeze while the access is in flight and
// write-enable gating so MEM/WB sees exactly one write per instruction.
// Build option: define MEM_TIMEOUT_EN to abandon a request after
// TIMEOUT_CYCLES REQ cycles and pulse mem_err; otherwise REQ waits forever.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memReadM,
    input  logic                  memWriteM,
    input  logic [WORD_WIDTH-1:0] aluOutM,
    input  logic [WORD_WIDTH-1:0] writeDataM,
    input  logic                  Regfile_weM,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_WIDTH-1:0] dmem_addr,
    output logic [WORD_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [WORD_WIDTH-1:0] dmem_rdata,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  stallM,
    output logic                  Regfile_weMG,
    output logic [WORD_WIDTH-1:0] readDataM,
    output logic                  mem_err
);

    mac_state_e            state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  acc;
    logic                  stall;
    logic                  timeout;

    assign acc = memReadM | memWriteM;

`ifdef MEM_TIMEOUT_EN
    logic cnt_clr;
    logic cnt_en;

    assign cnt_clr = (state_q == MacIdle) && acc;
    assign cnt_en  = (state_q == MacReq);

    mem_timeout_cnt #(
        .MaxCount (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (timeout)
    );
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    // Next-state and handshake register updates.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            MacIdle: begin
                if (acc) begin
                    addr_d  = aluOutM;
                    wdata_d = writeDataM;
                    we_d    = memWriteM;
                    req_d   = 1'b1;
                    state_d = MacReq;
                end
            end
            MacReq: begin
                // Ack wins over a timeout landing on the same cycle.
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = dmem_rdata;
                    end
                    state_d = MacDone;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    rdata_d = ZERO_WORD;
                    err_d   = 1'b1;
                    state_d = MacDone;
                end
            end
            MacDone: begin
                state_d = MacIdle;
            end
            default: begin
                state_d = MacIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and handshake registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MacIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ZERO_WORD;
            wdata_q <= ZERO_WORD;
            rdata_q <= ZERO_WORD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Freeze the front of the pipe until the DONE cycle releases it.
    always_comb begin
        stall        = acc && (state_q != MacDone);
        stallF       = stall;
        stallD       = stall;
        stallE       = stall;
        stallM       = stall;
        Regfile_weMG = Regfile_weM && !stall;
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign readDataM  = rdata_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized
// instruction streams checked against a per-instruction timeline model.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReadM, memWriteM, Regfile_weM;
    logic [31:0] aluOutM, writeDataM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stallF, stallD, stallE, stallM;
    logic        Regfile_weMG;
    logic [31:0] readDataM;
    logic        mem_err;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd_model;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memReadM     (memReadM),
        .memWriteM    (memWriteM),
        .aluOutM      (aluOutM),
        .writeDataM   (writeDataM),
        .Regfile_weM  (Regfile_weM),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .stallM       (stallM),
        .Regfile_weMG (Regfile_weMG),
        .readDataM    (readDataM),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check(tag, {28'd0, stallF, stallD, stallE, stallM}, {28'd0, {4{exp}}});
    endtask

    // Advance to just after the next rising edge, where inputs change.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = non-memory, 1 = load, 2 = store. The ack arrives in REQ cycle
    // number wait_n (0-based). Called with the current cycle being the one in
    // which the instruction sits in EX/MEM for the first time.
    task automatic run_instr(input int kind, input logic [31:0] addr, input logic [31:0] data,
                             input logic we, input int wait_n, input logic [31:0] rdata);
        memReadM    = (kind == 1);
        memWriteM   = (kind == 2);
        aluOutM     = addr;
        writeDataM  = data;
        Regfile_weM = we;
        dmem_ack    = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        @(negedge clk);
        if (kind == 0) begin
            check_stall("alu_stall", 1'b0);
            check("alu_weMG", {31'd0, Regfile_weMG}, {31'd0, we});
            check("alu_req", {31'd0, dmem_req}, 32'd0);
            check("alu_rdata", readDataM, rd_model);
            check("alu_err", {31'd0, mem_err}, 32'd0);
            next_cycle();
            return;
        end
        // First cycle: seen in IDLE, stall immediately, request not yet up.
        check_stall("idle_stall", 1'b1);
        check("idle_weMG", {31'd0, Regfile_weMG}, 32'd0);
        check("idle_req", {31'd0, dmem_req}, 32'd0);
        next_cycle();
        for (int i = 0; i <= wait_n; i++) begin
            dmem_ack   = (i == wait_n);
            dmem_rdata = (i == wait_n) ? rdata : $urandom;
            @(negedge clk);
            check("req_req", {31'd0, dmem_req}, 32'd1);
            check_stall("req_stall", 1'b1);
            check("req_weMG", {31'd0, Regfile_weMG}, 32'd0);
            check("req_we", {31'd0, dmem_we}, {31'd0, kind == 2});
            check("req_addr", dmem_addr, addr);
            check("req_wdata", dmem_wdata, data);
            next_cycle();
        end
        if (kind == 1) rd_model = rdata;
        // DONE: released, one write-enable pulse, ack here must be ignored.
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        @(negedge clk);
        check_stall("done_stall", 1'b0);
        check("done_req", {31'd0, dmem_req}, 32'd0);
        check("done_rdata", readDataM, rd_model);
        check("done_weMG", {31'd0, Regfile_weMG}, {31'd0, we});
        check("done_err", {31'd0, mem_err}, 32'd0);
        next_cycle();
    endtask

    initial begin
        rst         = 1'b0;
        memReadM    = 1'b0;
        memWriteM   = 1'b0;
        Regfile_weM = 1'b0;
        aluOutM     = '0;
        writeDataM  = '0;
        dmem_ack    = 1'b0;
        dmem_rdata  = '0;
        rd_model    = '0;

        @(negedge clk);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_rdata", readDataM, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // Directed: ADD, LW with immediate ack, SW with 4 waits, LW/LW.
        run_instr(0, 32'h0000_0040, 32'h5, 1'b1, 0, 32'h0);
        run_instr(1, 32'h0000_0100, 32'h0, 1'b1, 0, 32'hDEAD_BEEF);
        run_instr(2, 32'h0000_0020, 32'h1234, 1'b0, 4, 32'h0);
        run_instr(1, 32'h0000_0200, 32'h0, 1'b1, 1, 32'h1111_2222);
        run_instr(1, 32'h0000_0204, 32'h0, 1'b1, 0, 32'h3333_4444);

        // Store interrupted by reset during REQ, then a load restarts cleanly.
        memReadM    = 1'b0;
        memWriteM   = 1'b1;
        aluOutM     = 32'h0000_0300;
        writeDataM  = 32'hCAFE_F00D;
        Regfile_weM = 1'b0;
        dmem_ack    = 1'b0;
        next_cycle();
        next_cycle();
        #1 rst = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        check("mid_rst_we", {31'd0, dmem_we}, 32'd0);
        check("mid_rst_addr", dmem_addr, 32'd0);
        check("mid_rst_wdata", dmem_wdata, 32'd0);
        check("mid_rst_rdata", readDataM, 32'd0);
        check_stall("mid_rst_stall", 1'b1);
        rd_model = '0;
        next_cycle();
        rst = 1'b1;
        run_instr(1, 32'h0000_0300, 32'h0, 1'b1, 2, 32'h0BAD_F00D);

`ifdef MEM_TIMEOUT_EN
        // Load with ack withheld: abandoned after TO REQ cycles.
        memReadM    = 1'b1;
        memWriteM   = 1'b0;
        aluOutM     = 32'h0000_0400;
        Regfile_weM = 1'b1;
        dmem_ack    = 1'b0;
        next_cycle();
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            check("to_req", {31'd0, dmem_req}, 32'd1);
            check("to_err_low", {31'd0, mem_err}, 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("to_req_drop", {31'd0, dmem_req}, 32'd0);
        check("to_err", {31'd0, mem_err}, 32'd1);
        check("to_rdata", readDataM, 32'd0);
        check_stall("to_stall", 1'b0);
        rd_model = '0;
        next_cycle();
        run_instr(0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_instr(kind, $urandom, $urandom, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 5), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
